// File: rtl/clk_gate_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl_pkg
// Shared definitions for the clock-gate controller: the 2-bit FSM state
// enum (also exported on state_o), raw encoding constants for the power
// manager side, and the hysteresis/settle counter width helper.
// ---------------------------------------------------------------------------
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKING    = 2'd3
    } clk_gate_state_e;

    localparam logic [1:0] STATE_ACTIVE    = 2'd0;
    localparam logic [1:0] STATE_IDLE_WAIT = 2'd1;
    localparam logic [1:0] STATE_GATED     = 2'd2;
    localparam logic [1:0] STATE_WAKING    = 2'd3;

    // Width of the shared idle/wake counter: clog2 of the larger limit,
    // never below one bit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl_if
// Four-phase sleep handshake between a power manager and a clock-gate
// controller.
//   sleep_req_i : level sleep request from the power manager
//   wake_i      : wake event (pulse or level) from the power manager
//   sleep_ack_o : high while the clock is gated or not yet stable
// master = power manager side, slave = controller side.
// ---------------------------------------------------------------------------
interface clk_gate_ctrl_if;

    logic sleep_req_i;
    logic wake_i;
    logic sleep_ack_o;

    modport master (
        output sleep_req_i,
        output wake_i,
        input  sleep_ack_o
    );

    modport slave (
        input  sleep_req_i,
        input  wake_i,
        output sleep_ack_o
    );

endinterface

// File: rtl/clk_gate_stat_cnt.sv
// ---------------------------------------------------------------------------
// clk_gate_stat_cnt
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count sticks at all-ones instead of wrapping.
//   clk_i : clock
//   rst_i : synchronous active-high reset (count -> 0)
//   clr_i : synchronous clear (count -> 0)
//   inc_i : increment enable
//   cnt_o : current count
// ---------------------------------------------------------------------------
module clk_gate_stat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
// Drives the enable of a clock-gate cell from the ungated clock. Runs the
// four-phase sleep handshake, waits IDLE_CYCLES non-busy cycles before
// gating and WAKE_CYCLES cycles after re-enabling before dropping the ack.
//   clk_i              : free-running clock
//   rst_i              : synchronous active-high reset
//   pm                 : sleep handshake (sleep_req_i, wake_i, sleep_ack_o)
//   busy_i             : gated-domain activity, blocks gating
//   test_en_i          : scan override, forces en_o high
//   en_o               : to clock-gate enable
//   state_o            : current FSM state
//   gated_cycles_o     : saturating count of cycles spent gated
//   gated_cycles_clr_i : synchronous clear of gated_cycles_o
// ---------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned STAT_W      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    clk_gate_ctrl_if.slave     pm,
    input  logic               busy_i,
    input  logic               test_en_i,
    output logic               en_o,
    output clk_gate_state_e    state_o,
    output logic [STAT_W-1:0]  gated_cycles_o,
    input  logic               gated_cycles_clr_i
);

    localparam int unsigned CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    clk_gate_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             en_q, en_d;
    logic             ack_q, ack_d;

    // State register; en_q/ack_q are registered so the gate enable is
    // never a decode of several state bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            en_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;

        unique case (state_q)
            ST_ACTIVE: begin
                if (!pm.sleep_req_i) begin
                    armed_d = 1'b1;
                end else if (armed_q && !busy_i) begin
                    state_d = ST_IDLE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_IDLE_WAIT: begin
                // wake_i has priority over reaching the gating threshold.
                if (!pm.sleep_req_i || pm.wake_i) begin
                    state_d = ST_ACTIVE;
                end else if (busy_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GATED: begin
                if (!pm.sleep_req_i || pm.wake_i) begin
                    state_d = ST_WAKING;
                    cnt_d   = '0;
                    // A forced wake under a held request disarms re-gating
                    // until the requester drops the request.
                    if (pm.wake_i && pm.sleep_req_i) begin
                        armed_d = 1'b0;
                    end
                end
            end
            ST_WAKING: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase

        en_d  = (state_d != ST_GATED);
        ack_d = (state_d == ST_GATED) || (state_d == ST_WAKING);
    end

    // Outputs.
    always_comb begin
        en_o           = en_q | test_en_i;
        pm.sleep_ack_o = ack_q;
        state_o        = state_q;
    end

    clk_gate_stat_cnt #(
        .WIDTH (STAT_W)
    ) u_stat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (gated_cycles_clr_i),
        .inc_i (state_q == ST_GATED),
        .cnt_o (gated_cycles_o)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
// Directed bench for clk_gate_ctrl. Two instances share the stimulus: one
// with the default 32-bit statistics counter and one with a 4-bit counter
// to exercise saturation. A phase/countdown model predicts every output
// each cycle; literal expectations along the script pin the model.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;
    import clk_gate_ctrl_pkg::*;

    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic wake = 1'b0;
    logic busy = 1'b0;
    logic test_en = 1'b0;
    logic clr = 1'b0;
    logic chk_on = 1'b0;

    logic            en0, en4;
    clk_gate_state_e st0, st4;
    logic [31:0]     stat0;
    logic [3:0]      stat4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl_if pm0 ();
    clk_gate_ctrl_if pm4 ();
    assign pm0.sleep_req_i = req;
    assign pm0.wake_i      = wake;
    assign pm4.sleep_req_i = req;
    assign pm4.wake_i      = wake;

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .STAT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .pm(pm0), .busy_i(busy), .test_en_i(test_en),
        .en_o(en0), .state_o(st0), .gated_cycles_o(stat0), .gated_cycles_clr_i(clr)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .STAT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .pm(pm4), .busy_i(busy), .test_en_i(test_en),
        .en_o(en4), .state_o(st4), .gated_cycles_o(stat4), .gated_cycles_clr_i(clr)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=active 1=waiting for idle 2=gated 3=waking.
    // quiet = non-busy cycles seen while waiting, wake_left = settle
    // cycles remaining, blocked = re-gating inhibited, gcount = cycles
    // gated since the last clear (unbounded; saturation applied on compare).
    int     m_phase = 0;
    int     m_quiet = 0;
    int     m_wake_left = 0;
    bit     m_blocked = 1'b0;
    longint m_gcount = 0;

    task automatic model_step();
        bit was_gated;
        was_gated = (m_phase == 2);
        if (rst) begin
            m_phase = 0; m_quiet = 0; m_wake_left = 0; m_blocked = 1'b0; m_gcount = 0;
            return;
        end
        if (clr) m_gcount = 0;
        else if (was_gated) m_gcount++;
        case (m_phase)
            0: begin
                if (!req) m_blocked = 1'b0;
                else if (!m_blocked && !busy) begin m_phase = 1; m_quiet = 0; end
            end
            1: begin
                if (!req || wake) m_phase = 0;
                else if (busy) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == IDLE) m_phase = 2;
                end
            end
            2: begin
                if (!req || wake) begin
                    if (wake && req) m_blocked = 1'b1;
                    m_phase = 3;
                    m_wake_left = WAKE;
                end
            end
            default: begin
                m_wake_left--;
                if (m_wake_left == 0) m_phase = 0;
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("en_o",        64'(en0), 64'((m_phase != 2) || test_en));
            check("sleep_ack_o", 64'(pm0.sleep_ack_o), 64'((m_phase == 2) || (m_phase == 3)));
            check("state_o",     64'(st0), 64'(m_phase));
            check("gated_cycles_o", 64'(stat0), 64'((m_gcount > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_gcount));
            check("en_o_w4",     64'(en4), 64'((m_phase != 2) || test_en));
            check("state_o_w4",  64'(st4), 64'(m_phase));
            check("gated_cycles_o_w4", 64'(stat4), 64'((m_gcount > 15) ? 15 : m_gcount));
        end
    end

    // Advance n clock edges; ends just after a falling edge.
    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset state", 64'(st0), 64'd0);
        check("reset en", 64'(en0), 64'd1);
        check("reset ack", 64'(pm0.sleep_ack_o), 64'd0);
        check("reset stat", 64'(stat0), 64'd0);

        // Gating latency: IDLE+1 edges after the request.
        req = 1'b1;
        step(16);
        check("pre-gate state", 64'(st0), 64'd1);
        check("pre-gate en", 64'(en0), 64'd1);
        step(1);
        check("gate state", 64'(st0), 64'd2);
        check("gate en", 64'(en0), 64'd0);
        check("gate ack", 64'(pm0.sleep_ack_o), 64'd1);
        step(4);
        check("stat after 4", 64'(stat0), 64'd4);

        // Test override while gated.
        test_en = 1'b1;
        #1;
        check("test_en comb", 64'(en0), 64'd1);
        step(3);
        check("test_en ack", 64'(pm0.sleep_ack_o), 64'd1);
        check("test_en state", 64'(st0), 64'd2);
        check("test_en stat", 64'(stat0), 64'd7);
        test_en = 1'b0;
        step(1);
        check("test_en off en", 64'(en0), 64'd0);

        // Request release: WAKING, WAKING, ACTIVE.
        req = 1'b0;
        step(1);
        check("rel N+1 en", 64'(en0), 64'd1);
        check("rel N+1 state", 64'(st0), 64'd3);
        step(1);
        check("rel N+2 ack", 64'(pm0.sleep_ack_o), 64'd1);
        step(1);
        check("rel N+3 ack", 64'(pm0.sleep_ack_o), 64'd0);
        check("rel N+3 state", 64'(st0), 64'd0);
        check("rel stat", 64'(stat0), 64'd9);

        // Busy pulse at cnt=10 restarts the hysteresis.
        req = 1'b1;
        step(11);
        busy = 1'b1;
        step(1);
        busy = 1'b0;
        step(15);
        check("busy pre-gate", 64'(st0), 64'd1);
        step(1);
        check("busy gate", 64'(st0), 64'd2);

        // Forced wake with request held: disarmed afterwards.
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check("wake state", 64'(st0), 64'd3);
        step(2);
        check("wake done", 64'(st0), 64'd0);
        check("wake stat", 64'(stat0), 64'd10);
        step(30);
        check("disarmed state", 64'(st0), 64'd0);
        check("disarmed en", 64'(en0), 64'd1);

        // Re-arm by dropping the request, then re-gate.
        req = 1'b0;
        step(1);
        req = 1'b1;
        step(17);
        check("regate state", 64'(st0), 64'd2);

        // Saturation of the 4-bit counter over 20 gated cycles.
        step(20);
        check("stat32 30", 64'(stat0), 64'd30);
        check("stat4 sat", 64'(stat4), 64'd15);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr stat", 64'(stat0), 64'd0);
        check("clr stat4", 64'(stat4), 64'd0);
        step(1);
        check("post-clr stat", 64'(stat0), 64'd1);

        // Release and wake together give a single wake.
        req = 1'b0;
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check("dual wake state", 64'(st0), 64'd3);
        step(2);
        check("dual wake done", 64'(st0), 64'd0);

        // wake_i beats the gating threshold in IDLE_WAIT.
        req = 1'b1;
        step(16);
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check("wake wins state", 64'(st0), 64'd0);
        check("wake wins en", 64'(en0), 64'd1);
        step(1);
        check("rewait state", 64'(st0), 64'd1);

        // Reset while gated.
        step(16);
        check("pre-reset gated", 64'(st0), 64'd2);
        rst = 1'b1;
        step(1);
        check("reset gated state", 64'(st0), 64'd0);
        check("reset gated en", 64'(en0), 64'd1);
        check("reset gated ack", 64'(pm0.sleep_ack_o), 64'd0);
        rst = 1'b0;
        req = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
